// File: rtl/wiz_pkg.sv
// Shared decode vocabulary: micro-op codes, immediate formats and RV32I major opcodes.
// Fetch-side generators and the decoder both import this package.
package wiz_pkg;

  typedef enum logic [4:0] {
    OP_LUI     = 5'd0,
    OP_ADD     = 5'd1,
    OP_SUB     = 5'd2,
    OP_ADDI    = 5'd3,
    OP_SLL     = 5'd4,
    OP_BEQ     = 5'd10,
    OP_AUIPC   = 5'd11,
    OP_JAL     = 5'd12,
    OP_JALR    = 5'd13,
    OP_BNE     = 5'd14,
    OP_BLT     = 5'd15,
    OP_BGE     = 5'd16,
    OP_BLTU    = 5'd17,
    OP_BGEU    = 5'd18,
    OP_SW      = 5'd20,
    OP_LW      = 5'd21,
    OP_ILLEGAL = 5'd31
  } op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

endpackage

// File: rtl/id_imm_gen.sv
// Immediate generator: reassembles and sign-extends the immediate for a given format.
// The opcode bits are not needed here, so only instr[31:7] comes in.
module id_imm_gen
  import wiz_pkg::*;
(
  input  logic [31:7] instr,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_instr_decode.sv
// Decode stage front end: cracks RV32I words into micro-ops and holds them in one
// ID register with valid/ready on both sides, flush, and a saturating illegal counter.
module id_instr_decode
  import wiz_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_instr,
  input  logic [31:0]          i_pc,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [4:0]           o_op,
  output logic [4:0]           o_rd,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic [31:0]          o_imm,
  output logic [31:0]          o_pc,
  output logic                 o_we,
  output logic                 o_illegal,
  output logic [ILL_CNT_W-1:0] o_ill_cnt
);

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  op_e         op_d;
  fmt_e        fmt_d;
  logic        wr_d;
  logic [31:0] imm_d;
  logic        acc;

  op_e                 op_p0;
  logic [4:0]          rd_p0, rs1_p0, rs2_p0;
  logic [31:0]         imm_p0, pc_p0;
  logic                we_p0, ill_p0, vld_p0;
  logic [ILL_CNT_W-1:0] ill_cnt_p0;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign f7  = i_instr[31:25];
  assign rd  = i_instr[11:7];

  always_comb begin
    op_d  = OP_ILLEGAL;
    fmt_d = FMT_R;
    wr_d  = 1'b0;
    case (opc)
      OPC_LUI:   begin op_d = OP_LUI;   fmt_d = FMT_U; wr_d = 1'b1; end
      OPC_AUIPC: begin op_d = OP_AUIPC; fmt_d = FMT_U; wr_d = 1'b1; end
      OPC_JAL:   begin op_d = OP_JAL;   fmt_d = FMT_J; wr_d = 1'b1; end
      OPC_JALR:  if (f3 == 3'b000) begin op_d = OP_JALR; fmt_d = FMT_I; wr_d = 1'b1; end
      OPC_LOAD:  if (f3 == 3'b010) begin op_d = OP_LW;   fmt_d = FMT_I; wr_d = 1'b1; end
      OPC_STORE: if (f3 == 3'b010) begin op_d = OP_SW;   fmt_d = FMT_S; end
      OPC_OPIMM: if (f3 == 3'b000) begin op_d = OP_ADDI; fmt_d = FMT_I; wr_d = 1'b1; end
      OPC_OP: begin
        wr_d = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: op_d = OP_ADD;
          {7'b0100000, 3'b000}: op_d = OP_SUB;
          {7'b0000000, 3'b001}: op_d = OP_SLL;
          default:              op_d = OP_ILLEGAL;
        endcase
      end
      OPC_BR: begin
        fmt_d = FMT_B;
        case (f3)
          3'b000:  op_d = OP_BEQ;
          3'b001:  op_d = OP_BNE;
          3'b100:  op_d = OP_BLT;
          3'b101:  op_d = OP_BGE;
          3'b110:  op_d = OP_BLTU;
          3'b111:  op_d = OP_BGEU;
          default: op_d = OP_ILLEGAL;
        endcase
      end
      default: op_d = OP_ILLEGAL;
    endcase
    // Illegal words carry no immediate and never write back.
    if (op_d == OP_ILLEGAL) begin
      fmt_d = FMT_R;
      wr_d  = 1'b0;
    end
  end

  id_imm_gen u_imm_gen (
    .instr (i_instr[31:7]),
    .fmt   (fmt_d),
    .imm   (imm_d)
  );

  assign o_ready = !vld_p0 || i_ready;
  assign acc     = i_valid && o_ready;

  // ID pipeline register (p0): flush beats accept, accept beats consume.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p0     <= 1'b0;
      op_p0      <= OP_ILLEGAL;
      rd_p0      <= '0;
      rs1_p0     <= '0;
      rs2_p0     <= '0;
      imm_p0     <= '0;
      pc_p0      <= '0;
      we_p0      <= 1'b0;
      ill_p0     <= 1'b0;
      ill_cnt_p0 <= '0;
    end else if (i_flush) begin
      vld_p0 <= 1'b0;
    end else if (acc) begin
      vld_p0 <= 1'b1;
      op_p0  <= op_d;
      rd_p0  <= rd;
      rs1_p0 <= i_instr[19:15];
      rs2_p0 <= i_instr[24:20];
      imm_p0 <= imm_d;
      pc_p0  <= i_pc;
      we_p0  <= wr_d && (rd != 5'd0);
      ill_p0 <= (op_d == OP_ILLEGAL);
      if (op_d == OP_ILLEGAL) ill_cnt_p0 <= sat_inc(ill_cnt_p0);
    end else if (i_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign o_valid   = vld_p0;
  assign o_op      = op_p0;
  assign o_rd      = rd_p0;
  assign o_rs1     = rs1_p0;
  assign o_rs2     = rs2_p0;
  assign o_imm     = imm_p0;
  assign o_pc      = pc_p0;
  assign o_we      = we_p0;
  assign o_illegal = ill_p0;
  assign o_ill_cnt = ill_cnt_p0;

endmodule

// File: tb/tb_id_instr_decode.sv
// Scoreboard bench for id_instr_decode: directed words with hand-decoded expectations,
// plus a second instance with a 2-bit illegal counter to observe saturation.
module tb_id_instr_decode;
  import wiz_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    op_e         op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        we, ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_flush, i_ready;
  logic [31:0] i_instr, i_pc;
  logic        o_ready, o_valid, o_we, o_illegal;
  logic [4:0]  o_op, o_rd, o_rs1, o_rs2;
  logic [31:0] o_imm, o_pc;
  logic [7:0]  o_ill_cnt;
  logic        r2_ready, r2_valid, r2_we, r2_illegal;
  logic [4:0]  r2_op, r2_rd, r2_rs1, r2_rs2;
  logic [31:0] r2_imm, r2_pc;
  logic [1:0]  r2_ill_cnt;

  vec_t sb[$];
  vec_t mon_e, tmp_e;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  id_instr_decode #(.ILL_CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_pc(o_pc), .o_we(o_we),
    .o_illegal(o_illegal), .o_ill_cnt(o_ill_cnt)
  );

  id_instr_decode #(.ILL_CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(r2_ready), .i_instr(i_instr),
    .i_pc(i_pc), .i_flush(i_flush), .o_valid(r2_valid), .i_ready(i_ready), .o_op(r2_op),
    .o_rd(r2_rd), .o_rs1(r2_rs1), .o_rs2(r2_rs2), .o_imm(r2_imm), .o_pc(r2_pc), .o_we(r2_we),
    .o_illegal(r2_illegal), .o_ill_cnt(r2_ill_cnt)
  );

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input op_e op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic we, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.we = we; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every transfer to execute must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready && !i_flush) begin
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_entry: got op %0d pc 0x%08h, required no entry", o_op, o_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("op",      32'(o_op),      32'(mon_e.op));
        chk("rd",      32'(o_rd),      32'(mon_e.rd));
        chk("rs1",     32'(o_rs1),     32'(mon_e.rs1));
        chk("rs2",     32'(o_rs2),     32'(mon_e.rs2));
        chk("imm",     o_imm,          mon_e.imm);
        chk("pc",      o_pc,           mon_e.pc);
        chk("we",      32'(o_we),      32'(mon_e.we));
        chk("illegal", 32'(o_illegal), 32'(mon_e.ill));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic send(input vec_t v, input logic fl);
    int n = 0;
    i_valid = 1'b1; i_instr = v.instr; i_pc = v.pc; i_flush = fl;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      nvec++;
      nmis++;
      $display("FAIL accept_timeout: o_ready %0b, required 1", o_ready);
    end else if (!fl) begin
      sb.push_back(v);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t v_addi, v_beq, v_lui, v_jal, v_add, v_sw, v_sub, v_nop, v_lw, v_ill, v_brill, v_addi2;

  initial begin
    v_addi  = mk(32'h00108093, 32'd32,  OP_ADDI,    5'd1,  5'd1,  5'd1,  32'h00000001, 1'b1, 1'b0);
    v_beq   = mk(32'hFE0086E3, 32'd36,  OP_BEQ,     5'd13, 5'd1,  5'd0,  32'hFFFFFFEC, 1'b0, 1'b0);
    v_lui   = mk(32'h00ABF437, 32'd40,  OP_LUI,     5'd8,  5'd23, 5'd10, 32'h00ABF000, 1'b1, 1'b0);
    v_jal   = mk(32'h201BF46F, 32'd44,  OP_JAL,     5'd8,  5'd23, 5'd1,  32'h000BFA00, 1'b1, 1'b0);
    v_add   = mk(32'h002081B3, 32'd48,  OP_ADD,     5'd3,  5'd1,  5'd2,  32'h00000000, 1'b1, 1'b0);
    v_sw    = mk(32'h00902223, 32'd52,  OP_SW,      5'd4,  5'd0,  5'd9,  32'h00000004, 1'b0, 1'b0);
    v_sub   = mk(32'h407302B3, 32'd56,  OP_SUB,     5'd5,  5'd6,  5'd7,  32'h00000000, 1'b1, 1'b0);
    v_nop   = mk(32'h00000013, 32'd60,  OP_ADDI,    5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0);
    v_lw    = mk(32'hFF812203, 32'd64,  OP_LW,      5'd4,  5'd2,  5'd24, 32'hFFFFFFF8, 1'b1, 1'b0);
    v_ill   = mk(32'hFFFFFFFF, 32'd68,  OP_ILLEGAL, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b0, 1'b1);
    v_brill = mk(32'h00002063, 32'd72,  OP_ILLEGAL, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1);
    v_addi2 = mk(32'h00108093, 32'd300, OP_ADDI,    5'd1,  5'd1,  5'd1,  32'h00000001, 1'b1, 1'b0);

    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1; i_instr = '0; i_pc = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid",   32'(o_valid),   32'd0);
    chk("rst_op",      32'(o_op),      32'd31);
    chk("rst_rd",      32'(o_rd),      32'd0);
    chk("rst_imm",     o_imm,          32'd0);
    chk("rst_pc",      o_pc,           32'd0);
    chk("rst_we",      32'(o_we),      32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk("rst_ill_cnt", 32'(o_ill_cnt), 32'd0);
    chk("rst_ready",   32'(o_ready),   32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    send(v_addi, 1'b0);
    send(v_beq, 1'b0);
    send(v_lui, 1'b0);
    send(v_jal, 1'b0);
    chk("no_bubble_valid", 32'(o_valid), 32'd1);
    chk("no_bubble_op",    32'(o_op),    32'(OP_JAL));

    // Stall with ADD held while SW waits at the input.
    send(v_add, 1'b0);
    i_ready = 1'b0;
    i_valid = 1'b1; i_instr = v_sw.instr; i_pc = v_sw.pc;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(o_ready), 32'd0);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_op",    32'(o_op),    32'(OP_ADD));
      chk("stall_rd",    32'(o_rd),    32'd3);
      chk("stall_pc",    o_pc,         32'd48);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    send(v_sw, 1'b0);
    send(v_sub, 1'b0);
    send(v_nop, 1'b0);
    send(v_lw, 1'b0);
    idle(2);

    // Three illegal words, middle one flushed.
    send(v_ill, 1'b0);
    idle(1);
    send(v_ill, 1'b1);
    chk("flush_accept_valid", 32'(o_valid), 32'd0);
    send(v_ill, 1'b0);
    idle(2);
    chk("ill_cnt_after_flush",   32'(o_ill_cnt),  32'd2);
    chk("ill_cnt2_after_flush",  32'(r2_ill_cnt), 32'd2);

    // Flush of a stalled entry with nothing incoming.
    send(v_sub, 1'b0);
    i_ready = 1'b0; i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_held_valid", 32'(o_valid), 32'd0);
    tmp_e = sb.pop_back();
    i_ready = 1'b1;

    send(v_ill, 1'b0);
    send(v_ill, 1'b0);
    send(v_brill, 1'b0);
    send(v_ill, 1'b0);
    idle(2);
    chk("ill_cnt_six",      32'(o_ill_cnt),  32'd6);
    chk("ill_cnt2_saturate", 32'(r2_ill_cnt), 32'd3);

    // Asynchronous reset while stalled.
    send(v_lw, 1'b0);
    i_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid",   32'(o_valid),   32'd0);
    chk("async_rst_op",      32'(o_op),      32'd31);
    chk("async_rst_ill_cnt", 32'(o_ill_cnt), 32'd0);
    chk("async_rst_ready",   32'(o_ready),   32'd1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; i_ready = 1'b1;
    send(v_addi2, 1'b0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    chk("queue_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_instr_decode.md
# id_instr_decode

Decode stage front end. Accepts 32-bit RV32I instruction words from fetch with a valid/ready handshake. Cracks each word into a decoded micro-op: op code, register indices and sign-extended immediate. Holds the result in a single ID pipeline register feeding the execute stage, and supports downstream stall, flush and illegal-instruction flagging.

## Interface

Parameters:
- `ILL_CNT_W`, default 8: width of the saturating illegal-instruction counter.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_valid`, in, 1: fetch presents an instruction.
- `o_ready`, out, 1: decoder accepts this cycle.
- `i_instr`, in, 32: raw instruction word.
- `i_pc`, in, 32: PC of `i_instr`.
- `i_flush`, in, 1: kill the held entry and any entry being accepted this cycle.
- `o_valid`, out, 1: decoded entry present.
- `i_ready`, in, 1: execute consumes this cycle.
- `o_op`, out, 5: decoded op code (`op_e`).
- `o_rd`, out, 5: destination register index.
- `o_rs1`, out, 5: source register 1 index.
- `o_rs2`, out, 5: source register 2 index.
- `o_imm`, out, 32: sign-extended immediate.
- `o_pc`, out, 32: PC of the held entry.
- `o_we`, out, 1: instruction writes `rd`, and `rd` is not 0.
- `o_illegal`, out, 1: held entry is unsupported.
- `o_ill_cnt`, out, `ILL_CNT_W`: saturating count of illegal instructions accepted.

## Operation

Op codes (`op_e`):
- LUI 0, ADD 1, SUB 2, ADDI 3, SLL 4
- BEQ 10, AUIPC 11, JAL 12, JALR 13, BNE 14, BLT 15, BGE 16, BLTU 17, BGEU 18
- SW 20, LW 21, ILLEGAL 31

Decode is purely combinational from `i_instr`:
- Opcode field is `[6:0]`, funct3 is `[14:12]`, funct7 is `[31:25]`.
- R-type (0110011): funct7/funct3 of 0000000/000 is ADD, 0100000/000 is SUB, 0000000/001 is SLL. Any other R-type combination is ILLEGAL.
- ADDI is 0010011 with funct3 000.
- LW is 0000011 with funct3 010.
- SW is 0100011 with funct3 010.
- JALR is 1100111 with funct3 000.
- Branches are 1100011. funct3 010 and 011 are ILLEGAL.
- Any other opcode is ILLEGAL.

Immediates:
- I-type: `{20{b31}, [31:20]}`.
- S-type: `{20{b31}, [31:25], [11:7]}`.
- B-type: `{19{b31}, b31, b7, [30:25], [11:8], 0}`.
- U-type: `{[31:12], 12'b0}`.
- J-type: `{11{b31}, b31, [19:12], b20, [30:21], 0}`.
- R-type: `o_imm` = 0.

Field and flag rules:
- `o_rs1`, `o_rs2` and `o_rd` always carry bits `[19:15]`, `[24:20]` and `[11:7]`, regardless of format.
- `o_we` is set for LUI, AUIPC, JAL, JALR, ADD, SUB, ADDI, SLL and LW when rd ≠ 0.
- For ILLEGAL entries, `o_we` = 0 and `o_imm` = 0.

Handshake:
- `o_ready = !o_valid || i_ready`. This is combinational and has no dependence on `i_valid`.
- Accept occurs when `i_valid && o_ready`. On accept, the register loads the decode of `i_instr`, `i_pc` is copied into `o_pc`, and `o_valid` goes to 1 the next cycle.
- Consume without accept: `o_valid` goes to 0.
- Consume and accept in the same cycle: the new entry replaces the old one, with no bubble.
- If `o_valid && !i_ready`, all outputs hold stable.

Flush:
- `i_flush` has priority over every other event.
- Next cycle `o_valid` = 0, regardless of `i_valid` or `i_ready`.
- Data outputs may keep stale values.
- Any accept in a flush cycle is discarded and is not counted.

Illegal counter:
- `o_ill_cnt` increments by 1 on each non-flushed accept whose decode is ILLEGAL.
- It saturates at all-ones.

## Timing

- Latency is 1 cycle from accept to `o_valid`.
- Throughput is 1 instruction per cycle while `i_ready` = 1.
- Reset values: `o_valid` = 0, `o_op` = ILLEGAL (31), `o_rd`/`o_rs1`/`o_rs2` = 0, `o_imm` = 0, `o_pc` = 0, `o_we` = 0, `o_illegal` = 0, `o_ill_cnt` = 0.
- Because of the rule above, `o_ready` = 1 during and after reset.
- Reset asserted mid-stall drops the held entry immediately (asynchronously). The first accept after reset deasserts is the first entry seen downstream.
- No combinational path from `i_instr` to any output. All decode outputs are registered.

## Structure

- Shared package `wiz_pkg`: `op_e` enum (5-bit, values above) and the opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP).
- The fetch-side instruction generator must import the same `op_e`.
- One sub-module, `id_imm_gen`: combinational, instruction in, 32-bit immediate out, selected by format.
- Format decode and the pipeline register live in `id_instr_decode`.

## Test plan

- Reset, then send `0x00108093` (ADDI x1,x1,1) with `i_ready` = 1 → next cycle `o_valid` = 1, `o_op` = 3, `o_rd` = 1, `o_rs1` = 1, `o_imm` = 1, `o_we` = 1.
- Send `0xFE0086E3` (BEQ x1,x0,-20) at pc 36 → `o_op` = 10, `o_rs1` = 1, `o_rs2` = 0, `o_imm` = `0xFFFFFFEC`, `o_pc` = 36, `o_we` = 0.
- Back-to-back `0x00ABF437` (LUI x8) then `0x201BF46F` (JAL x8) → consecutive cycles give `o_imm` = `0x00ABF000` (op 0), then `0x000BFA00` (op 12). No bubble.
- Hold `i_ready` = 0 with an entry held, present `0x00902223` (SW) → `o_ready` = 0 and outputs stable. Release `i_ready` → SW appears with `o_op` = 20, `o_rs2` = 9, `o_imm` = 4, `o_we` = 0.
- Present `0xFFFFFFFF` three times with `i_flush` on the second → `o_illegal` = 1 on the first and third entries, `o_ill_cnt` = 2. With `ILL_CNT_W` = 2, six illegal words → `o_ill_cnt` stays at 3.
- Assert `i_rst` asynchronously while `o_valid` = 1 and stalled → `o_valid` = 0 and `o_op` = 31 immediately. The first accepted word after release decodes correctly.
